// File: rtl/pwr_rst_seq_pkg.sv
// Shared state encoding and unlock key for the power/reset sequencer.
package pwr_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SYS_RUN = 3'd3,
    ST_RUN     = 3'd4,
    ST_PWR_DN  = 3'd5
  } seq_state_e;

  localparam logic [15:0] SEQ_KEY = 16'hA520;

endpackage

// File: rtl/pwr_rst_seq_timer.sv
// Clearable saturating up-counter; tc flags when the count equals tc_val.
module seq_timer
  import pwr_rst_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/pwr_rst_seq.sv
// Rail power-up/down and reset-release sequencer.
// Define PWR_RST_SEQ_KEY_EN to require the unlock key before leaving OFF.
//
//   state      | meaning
//   OFF        | all rails off, waiting for start
//   PWR_UP     | enabling rails one per PWR_STEP
//   SETTLE     | rails on, both resets held for RST_DLY
//   SYS_RUN    | system reset released, core held for CORE_DLY
//   RUN        | both resets released
//   PWR_DN     | disabling rails highest-first, one per PWR_STEP
module pwr_rst_seq
  import pwr_rst_seq_pkg::*;
#(
  parameter int N_DOMAINS = 2,
  parameter int CNT_W     = 16,
  parameter int PWR_STEP  = 20,
  parameter int RST_DLY   = 1000,
  parameter int CORE_DLY  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef PWR_RST_SEQ_KEY_EN
  input  logic                 key_valid,
  input  logic [15:0]          key,
`endif
  input  logic                 sw_rst_req,
  input  logic                 pwr_down_req,
  output logic [N_DOMAINS-1:0] pwr_en_o,
  output logic                 rst_o,
  output logic                 core_rst_o,
  output logic [2:0]           state_o
);

  localparam int IDX_W = $clog2(N_DOMAINS + 1);

  seq_state_e           state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [N_DOMAINS-1:0] pwr_en_n;
  logic                 rst_nx, core_rst_nx;
  logic                 tmr_clr, tmr_tc;
  logic [CNT_W-1:0]     tc_val;
  logic                 start;

`ifdef PWR_RST_SEQ_KEY_EN
  logic key_hit, key_latched;

  assign key_hit = key_valid && (key == SEQ_KEY);
  assign start   = key_hit || key_latched;

  // The unlock is consumed whenever the sequencer falls back to OFF.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_latched <= 1'b0;
    end else if (state_n == ST_OFF && state != ST_OFF) begin
      key_latched <= 1'b0;
    end else if (key_hit) begin
      key_latched <= 1'b1;
    end
  end
`else
  assign start = 1'b1;
`endif

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clr),
    .tc_val (tc_val),
    .tc     (tmr_tc)
  );

  // idx counts enabled rails; rails fill contiguously from bit 0.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    pwr_en_n = pwr_en_o;
    tmr_clr  = 1'b0;
    tc_val   = CNT_W'(PWR_STEP - 1);
    case (state)
      ST_OFF: begin
        if (start && !pwr_down_req) state_n = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (pwr_down_req) begin
          state_n = (idx == '0) ? ST_OFF : ST_PWR_DN;
        end else if (tmr_tc) begin
          pwr_en_n = pwr_en_o | (N_DOMAINS'(1) << idx);
          idx_n    = idx + 1'b1;
          tmr_clr  = 1'b1;
          if (idx == IDX_W'(N_DOMAINS - 1)) state_n = ST_SETTLE;
        end
      end
      ST_SETTLE, ST_SYS_RUN, ST_RUN: begin
        tc_val = (state == ST_SETTLE) ? CNT_W'(RST_DLY - 1) : CNT_W'(CORE_DLY - 1);
        if (pwr_down_req) begin
          state_n = ST_PWR_DN;
        end else if (sw_rst_req) begin
          state_n = ST_SETTLE;
          tmr_clr = 1'b1;
        end else if (tmr_tc && state == ST_SETTLE) begin
          state_n = ST_SYS_RUN;
        end else if (tmr_tc && state == ST_SYS_RUN) begin
          state_n = ST_RUN;
        end
      end
      ST_PWR_DN: begin
        if (idx == '0) begin
          state_n = ST_OFF;
        end else if (tmr_tc) begin
          pwr_en_n = pwr_en_o & ~(N_DOMAINS'(1) << (idx - 1'b1));
          idx_n    = idx - 1'b1;
          tmr_clr  = 1'b1;
          if (idx == IDX_W'(1)) state_n = ST_OFF;
        end
      end
      default: state_n = ST_OFF;
    endcase
    if (state_n != state) tmr_clr = 1'b1;
    rst_nx      = !(state_n == ST_SYS_RUN || state_n == ST_RUN);
    core_rst_nx = (state_n != ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_OFF;
      idx        <= '0;
      pwr_en_o   <= '0;
      rst_o      <= 1'b1;
      core_rst_o <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pwr_en_o   <= pwr_en_n;
      rst_o      <= rst_nx;
      core_rst_o <= core_rst_nx;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pwr_rst_seq.sv
// Self-checking bench for pwr_rst_seq: timeline model plus directed checks.
module tb_pwr_rst_seq;
  import pwr_rst_seq_pkg::*;

  localparam int N    = 2;
  localparam int STEP = 20;
  localparam int RDLY = 1000;
  localparam int CDLY = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         sw_rst_req = 1'b0;
  logic         pwr_down_req = 1'b0;
  logic [N-1:0] pwr_en_o;
  logic         rst_o;
  logic         core_rst_o;
  logic [2:0]   state_o;
`ifdef PWR_RST_SEQ_KEY_EN
  logic         key_valid = 1'b1;
  logic [15:0]  key = 16'hA520;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pwr_rst_seq #(
    .N_DOMAINS (N),
    .CNT_W     (16),
    .PWR_STEP  (STEP),
    .RST_DLY   (RDLY),
    .CORE_DLY  (CDLY)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef PWR_RST_SEQ_KEY_EN
    .key_valid    (key_valid),
    .key          (key),
`endif
    .sw_rst_req   (sw_rst_req),
    .pwr_down_req (pwr_down_req),
    .pwr_en_o     (pwr_en_o),
    .rst_o        (rst_o),
    .core_rst_o   (core_rst_o),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a single timeline t from power-up entry (software reset rewinds
  // it to the SETTLE start), and a separate down-count timeline d.
  localparam int M_OFF = 0;
  localparam int M_SEQ = 1;
  localparam int M_DN  = 2;

  int           m_mode, m_t, m_d, m_r0;
  int           e_rails;
  logic [2:0]   e_state;
  logic [N-1:0] e_en;
  logic         e_rst, e_core;

  always_comb begin
    e_rails = 0;
    e_state = ST_OFF;
    if (m_mode == M_SEQ) begin
      e_rails = (m_t / STEP < N) ? m_t / STEP : N;
      if (m_t < N * STEP)                    e_state = ST_PWR_UP;
      else if (m_t < N * STEP + RDLY)        e_state = ST_SETTLE;
      else if (m_t < N * STEP + RDLY + CDLY) e_state = ST_SYS_RUN;
      else                                   e_state = ST_RUN;
    end else if (m_mode == M_DN) begin
      e_rails = m_r0 - m_d / STEP;
      e_state = ST_PWR_DN;
    end
    e_en   = N'((1 << e_rails) - 1);
    e_rst  = !(e_state == ST_SYS_RUN || e_state == ST_RUN);
    e_core = (e_state != ST_RUN);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode <= M_OFF;
      m_t    <= 0;
      m_d    <= 0;
      m_r0   <= 0;
    end else begin
      case (m_mode)
        M_OFF: if (!pwr_down_req) begin
          m_mode <= M_SEQ;
          m_t    <= 0;
        end
        M_SEQ: begin
          if (pwr_down_req) begin
            if (e_rails == 0) m_mode <= M_OFF;
            else begin
              m_mode <= M_DN;
              m_d    <= 0;
              m_r0   <= e_rails;
            end
          end else if (sw_rst_req && m_t >= N * STEP) begin
            m_t <= N * STEP;
          end else if (m_t < 100000) begin
            m_t <= m_t + 1;
          end
        end
        default: begin
          m_d <= m_d + 1;
          if (m_r0 - (m_d + 1) / STEP <= 0) m_mode <= M_OFF;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    chk("cyc_state", 32'(state_o), 32'(e_state));
    chk("cyc_en", 32'(pwr_en_o), 32'(e_en));
    chk("cyc_rst", 32'(rst_o), 32'(e_rst));
    chk("cyc_core", 32'(core_rst_o), 32'(e_core));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    cyc(3);
    chk("rst_state", 32'(state_o), 32'(ST_OFF));
    chk("rst_en", 32'(pwr_en_o), 0);
    chk("rst_rst", 32'(rst_o), 1);
    chk("rst_core", 32'(core_rst_o), 1);

    // Power-up from reset release
    reset = 1'b0;
    cyc(1);
    chk("up_entry", 32'(state_o), 32'(ST_PWR_UP));
    cyc(19);
    chk("up_en19", 32'(pwr_en_o), 32'h0);
    cyc(1);
    chk("up_en20", 32'(pwr_en_o), 32'h1);
    chk("model_en20", 32'(e_en), 32'h1);
    cyc(20);
    chk("up_en40", 32'(pwr_en_o), 32'h3);
    chk("up_settle", 32'(state_o), 32'(ST_SETTLE));
    cyc(999);
    chk("rst_hold", 32'(rst_o), 1);
    cyc(1);
    chk("rst_rel", 32'(rst_o), 0);
    chk("model_rst", 32'(e_rst), 0);
    cyc(15);
    chk("core_hold", 32'(core_rst_o), 1);
    cyc(1);
    chk("core_rel", 32'(core_rst_o), 0);
    chk("run", 32'(state_o), 32'(ST_RUN));
    chk("model_run", 32'(e_state), 32'(ST_RUN));
    cyc(10);

    // Software reset in RUN
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    chk("sw_rst", 32'(rst_o), 1);
    chk("sw_core", 32'(core_rst_o), 1);
    chk("sw_en", 32'(pwr_en_o), 32'h3);
    chk("sw_state", 32'(state_o), 32'(ST_SETTLE));
    cyc(999);
    chk("sw_rst_hold", 32'(rst_o), 1);
    cyc(1);
    chk("sw_rst_rel", 32'(rst_o), 0);
    cyc(15);
    chk("sw_core_hold", 32'(core_rst_o), 1);
    cyc(1);
    chk("sw_core_rel", 32'(core_rst_o), 0);
    cyc(5);

    // Power-down from RUN
    pwr_down_req = 1'b1;
    cyc(1);
    chk("dn_state", 32'(state_o), 32'(ST_PWR_DN));
    chk("dn_rst", 32'(rst_o), 1);
    chk("dn_core", 32'(core_rst_o), 1);
    chk("dn_en0", 32'(pwr_en_o), 32'h3);
    cyc(19);
    chk("dn_en19", 32'(pwr_en_o), 32'h3);
    cyc(1);
    chk("dn_en20", 32'(pwr_en_o), 32'h1);
    cyc(20);
    chk("dn_en40", 32'(pwr_en_o), 32'h0);
    chk("dn_off", 32'(state_o), 32'(ST_OFF));
    cyc(5);
    chk("off_held", 32'(state_o), 32'(ST_OFF));

    // Auto restart; software reset ignored in PWR_UP
    pwr_down_req = 1'b0;
    cyc(1);
    chk("re_up", 32'(state_o), 32'(ST_PWR_UP));
    cyc(4);
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    chk("sw_ign_up", 32'(state_o), 32'(ST_PWR_UP));
    cyc(35);
    chk("re_settle", 32'(state_o), 32'(ST_SETTLE));

    // Power-down and software reset together at SETTLE cycle 500
    cyc(500);
    pwr_down_req = 1'b1;
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    chk("both_state", 32'(state_o), 32'(ST_PWR_DN));
    chk("both_rst", 32'(rst_o), 1);
    chk("both_en", 32'(pwr_en_o), 32'h3);
    cyc(20);
    chk("both_en20", 32'(pwr_en_o), 32'h1);
    cyc(20);
    chk("both_en40", 32'(pwr_en_o), 32'h0);
    chk("both_off", 32'(state_o), 32'(ST_OFF));

    // Power-down part-way through PWR_UP with one rail on
    pwr_down_req = 1'b0;
    cyc(1);
    cyc(25);
    chk("part_en", 32'(pwr_en_o), 32'h1);
    pwr_down_req = 1'b1;
    cyc(1);
    chk("part_dn", 32'(state_o), 32'(ST_PWR_DN));
    cyc(19);
    chk("part_en19", 32'(pwr_en_o), 32'h1);
    cyc(1);
    chk("part_en20", 32'(pwr_en_o), 32'h0);
    chk("part_off", 32'(state_o), 32'(ST_OFF));

    // Power-down with no rail on goes straight to OFF
    pwr_down_req = 1'b0;
    cyc(1);
    chk("zero_up", 32'(state_o), 32'(ST_PWR_UP));
    pwr_down_req = 1'b1;
    cyc(1);
    chk("zero_off", 32'(state_o), 32'(ST_OFF));
    chk("zero_en", 32'(pwr_en_o), 32'h0);

    // Asynchronous reset mid-RUN, checked before the next clock edge
    pwr_down_req = 1'b0;
    cyc(1);
    cyc(1060);
    chk("run2", 32'(state_o), 32'(ST_RUN));
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state_o), 32'(ST_OFF));
    chk("async_en", 32'(pwr_en_o), 32'h0);
    chk("async_rst", 32'(rst_o), 1);
    chk("async_core", 32'(core_rst_o), 1);
    cyc(2);
    reset = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_rst_seq.md
PWR_RST_SEQ -- requirements
Module: pwr_rst_seq

Interface
REQ-001 Parameter N_DOMAINS, default 2: number of power rails, sequenced in index order (1..8).
REQ-002 Parameter CNT_W, default 16: timer width; every delay parameter SHALL fit in CNT_W bits.
REQ-003 Parameter PWR_STEP, default 20: cycles between successive rail enables/disables (>=1).
REQ-004 Parameter RST_DLY, default 1000: cycles from SETTLE entry to rst_o release (>=1).
REQ-005 Parameter CORE_DLY, default 16: cycles from rst_o release to core_rst_o release (>=1).
REQ-006 clock  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sw_rst_req  input  1  single-cycle pulse: re-run the reset window with rails held on.
REQ-009 pwr_down_req  input  1  level: sequence all rails off.
REQ-010 pwr_en_o  output  N_DOMAINS  rail enables, bit i = rail i.
REQ-011 rst_o  output  1  system reset, active-high.
REQ-012 core_rst_o  output  1  core reset, active-high.
REQ-013 state_o  output  3  current state encoding.

Function
REQ-014 States: OFF, PWR_UP, SETTLE, SYS_RUN, RUN, PWR_DN; all outputs SHALL be registered.
REQ-015 OFF->PWR_UP on the first edge with start condition true and pwr_down_req low; timer cleared.
REQ-016 PWR_UP: set the next rail bit every PWR_STEP cycles, so rail i rises (i+1)*PWR_STEP cycles after entry; after the last rail -> SETTLE.
REQ-017 SETTLE: after RST_DLY cycles -> SYS_RUN with rst_o low.
REQ-018 SYS_RUN: after CORE_DLY cycles -> RUN with core_rst_o low.
REQ-019 rst_o SHALL be high in every state except SYS_RUN and RUN; core_rst_o SHALL be high in every state except RUN.
REQ-020 sw_rst_req in RUN, SETTLE or SYS_RUN -> SETTLE, timer cleared, both resets high on the next edge, pwr_en_o unchanged; SHALL be ignored in OFF, PWR_UP, PWR_DN.
REQ-021 pwr_down_req high in PWR_UP, SETTLE, SYS_RUN or RUN -> PWR_DN on the next edge, both resets high, timer cleared; if no rail is enabled -> OFF directly.
REQ-022 PWR_DN: clear the highest set rail bit every PWR_STEP cycles; after bit 0 clears -> OFF.
REQ-023 pwr_down_req and sw_rst_req on the same edge: pwr_down_req SHALL win.
REQ-024 Timer SHALL never wrap; it is cleared on every state change.

Reset
REQ-025 reset high SHALL immediately, without a clock edge, force state OFF, pwr_en_o all-zero, rst_o=1, core_rst_o=1, timer=0, rail index=0.

Configuration
REQ-026 PWR_RST_SEQ_KEY_EN defined: adds inputs key_valid (1) and key (16); start condition = key_valid && key==16'hA520, latched until OFF is re-entered.
REQ-027 PWR_RST_SEQ_KEY_EN undefined: start condition is constant true (auto-start after reset or power-down once pwr_down_req is low).

Structure
REQ-028 Package pwr_rst_seq_pkg SHALL hold the state enum and the constant SEQ_KEY=16'hA520.
REQ-029 One sub-module, seq_timer (CNT_W-bit clearable up-counter with terminal-count compare), SHALL be used.

Verification (N_DOMAINS=2, defaults)
REQ-030 Reset release -> pwr_en_o 2'b01 at PWR_UP+20, 2'b11 at +40, rst_o low at +1040, core_rst_o low at +1056.
REQ-031 sw_rst_req pulse in RUN -> both resets high next cycle, pwr_en_o stays 2'b11, rst_o low 1000 cycles later, core_rst_o 16 after.
REQ-032 pwr_down_req in RUN -> resets high next cycle, pwr_en_o 2'b01 after 20, 2'b00 after 40, state OFF.
REQ-033 pwr_down_req at cycle 500 of SETTLE together with sw_rst_req -> power-down as REQ-032, sw_rst_req ignored.
REQ-034 reset asserted mid-RUN between edges -> outputs at reset values before the next edge.
REQ-035 With PWR_RST_SEQ_KEY_EN: key=16'h1234 -> stays OFF; key=16'hA520 -> sequence per REQ-030.
